// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: collects NBYTES uart bytes into one frame word and
// holds the last good frame for the display path.
// Optional feature macro: RX_FRAME_CHECKSUM_EN adds a trailing XOR byte per
// frame; a mismatch is treated like a uart error.
// Byte handshake: rx_valid carries no ready. A byte is taken only on the
// rising edge of rx_valid, so a level held high for many cycles still counts
// as one byte; a new byte needs rx_valid to drop for at least one cycle.
module rx_frame_assembler #(
    parameter int          NBYTES       = 2,
    parameter int          TIMEOUT_CYC  = 100000,
    parameter logic [15:0] INIT_PATTERN = 16'hCCCC,
    parameter logic [15:0] ERR_PATTERN  = 16'hEEEE,
    localparam int         DATA_W       = 8 * NBYTES,
    localparam int         CNT_W        = $clog2(NBYTES + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferror,
    input  logic              rx_perror,
    input  logic              clr_err,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    output logic              frame_error,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [1:0]        state_dbg
);

`ifdef RX_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 1;
`else
    localparam int FRAME_LEN = NBYTES;
`endif
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] INIT_W = DATA_W'(INIT_PATTERN);
    localparam logic [DATA_W-1:0] ERR_W  = DATA_W'(ERR_PATTERN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic              rx_valid_q;
    logic [DATA_W-1:0] shift_q, shift_nxt, word_next;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [TMO_W-1:0]  tmo_q, tmo_nxt;
    logic              stb, err, last_byte;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0]        csum_q, csum_nxt;
    logic              csum_ok;
    assign csum_ok = (rx_data == csum_q);
`endif

    assign stb       = rx_valid & ~rx_valid_q;
    assign err       = rx_ferror | rx_perror;
    assign last_byte = (byte_cnt == CNT_W'(FRAME_LEN - 1));
    assign state_dbg = state_q;

    // Current partial word with the incoming byte placed in its lane (first byte = MSB lane).
    always_comb begin
        word_next = shift_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (int'(byte_cnt) == i) word_next[DATA_W-1-8*i -: 8] = rx_data;
        end
    end

    // Next-state and next-output logic; uart error overrides everything else.
    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        data_nxt  = frame_data;
        valid_nxt = 1'b0;
        cnt_nxt   = byte_cnt;
        tmo_nxt   = tmo_q;
`ifdef RX_FRAME_CHECKSUM_EN
        csum_nxt  = csum_q;
`endif
        unique case (state_q)
            IDLE, COLLECT: begin
                if (stb) begin
                    shift_nxt = word_next;
                    tmo_nxt   = '0;
                    if (last_byte) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
`ifdef RX_FRAME_CHECKSUM_EN
                        csum_nxt = '0;
                        if (csum_ok) begin
                            data_nxt  = shift_q;
                            valid_nxt = 1'b1;
                        end else begin
                            state_nxt = ERROR;
                            data_nxt  = ERR_W;
                        end
`else
                        data_nxt  = word_next;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        cnt_nxt   = byte_cnt + CNT_W'(1);
                        state_nxt = COLLECT;
`ifdef RX_FRAME_CHECKSUM_EN
                        csum_nxt  = csum_q ^ rx_data;
`endif
                    end
                end else if (state_q == COLLECT) begin
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Inter-byte gap too long: drop the partial frame.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        tmo_nxt   = '0;
`ifdef RX_FRAME_CHECKSUM_EN
                        csum_nxt  = '0;
`endif
                    end else begin
                        tmo_nxt = tmo_q + TMO_W'(1);
                    end
                end
            end
            ERROR: begin
                cnt_nxt = '0;
                tmo_nxt = '0;
                if (clr_err && !err) begin
                    state_nxt = IDLE;
                    data_nxt  = INIT_W;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (err) begin
            state_nxt = ERROR;
            data_nxt  = ERR_W;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_nxt  = '0;
`endif
        end
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            shift_q     <= '0;
            frame_data  <= INIT_W;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            byte_cnt    <= '0;
            tmo_q       <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            rx_valid_q  <= rx_valid;
            shift_q     <= shift_nxt;
            frame_data  <= data_nxt;
            frame_valid <= valid_nxt;
            frame_error <= (state_nxt == ERROR);
            byte_cnt    <= cnt_nxt;
            tmo_q       <= tmo_nxt;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_q      <= csum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: two instances share data/error/clear inputs,
// dut_a (long timeout) and dut_b (TIMEOUT_CYC=20), each with its own rx_valid.
module tb_rx_frame_assembler;
    localparam int NB = 2;
    localparam int DW = 8 * NB;
    localparam int CW = $clog2(NB + 2);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid_a = 1'b0, rx_valid_b = 1'b0;
    logic          rx_ferror = 1'b0, rx_perror = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] fd_a, fd_b;
    logic          fv_a, fv_b, fe_a, fe_b;
    logic [CW-1:0] bc_a, bc_b;
    logic [1:0]    st_a, st_b;

    int n_chk = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    rx_frame_assembler #(.NBYTES(NB)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .rx_ferror(rx_ferror), .rx_perror(rx_perror), .clr_err(clr_err),
        .frame_data(fd_a), .frame_valid(fv_a), .frame_error(fe_a),
        .byte_cnt(bc_a), .state_dbg(st_a)
    );

    rx_frame_assembler #(.NBYTES(NB), .TIMEOUT_CYC(20)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .rx_ferror(rx_ferror), .rx_perror(rx_perror), .clr_err(clr_err),
        .frame_data(fd_b), .frame_valid(fv_b), .frame_error(fe_b),
        .byte_cnt(bc_b), .state_dbg(st_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte: a low cycle, then rx_valid high for one cycle; returns just after the strobe edge.
    task automatic send_byte(input logic [7:0] b, input logic pe, input logic sel_b);
        @(negedge clk);
        rx_data   = b;
        rx_perror = pe;
        if (sel_b) rx_valid_b = 1'b1;
        else       rx_valid_a = 1'b1;
        @(negedge clk);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        rx_perror  = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Scoreboard: every frame_valid pulse on dut_a must match the next expected frame.
    always @(negedge clk) begin
        if (fv_a) begin
            if (exp_q.size() == 0) check("unexp_valid", 32'(fv_a), 32'd0);
            else                   check("sb_frame", 32'(fd_a), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        // Reset held low for 3 clocks
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", fd_a, 16'hCCCC);
        check("rst_valid", fv_a, 0);
        check("rst_error", fe_a, 0);
        check("rst_cnt", bc_a, 0);
        check("rst_state", st_a, 0);
        reset = 1'b1;

        // Two-byte frame
        exp_q.push_back(16'h1234);
        send_byte(8'h12, 1'b0, 1'b0);
        check("f1_cnt1", bc_a, 1);
        check("f1_novalid", fv_a, 0);
        send_byte(8'h34, 1'b0, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'h26, 1'b0, 1'b0);
`endif
        check("f1_data", fd_a, 16'h1234);
        check("f1_valid", fv_a, 1);
        check("f1_cnt0", bc_a, 0);
        @(negedge clk);
        check("f1_valid_pulse", fv_a, 0);

        // Level-held rx_valid counts once
        @(negedge clk);
        rx_data = 8'hAB;
        rx_valid_a = 1'b1;
        repeat (50) @(negedge clk);
        rx_valid_a = 1'b0;
        check("hold_cnt", bc_a, 1);
        check("hold_data", fd_a, 16'h1234);
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD, 1'b0, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'hAB ^ 8'hCD, 1'b0, 1'b0);
`endif
        check("hold_frame", fd_a, 16'hABCD);

        // Inter-byte timeout on dut_b
        send_byte(8'h55, 1'b0, 1'b1);
        check("to_cnt1", bc_b, 1);
        repeat (19) @(negedge clk);
        check("to_before", bc_b, 1);
        @(negedge clk);
        check("to_after", bc_b, 0);
        check("to_state", st_b, 0);
        check("to_data_kept", fd_b, 16'hCCCC);
        check("to_novalid", fv_b, 0);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b1);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'h03, 1'b0, 1'b1);
`endif
        check("to_frame", fd_b, 16'h0102);
        check("to_valid", fv_b, 1);

        // Parity error on the 2nd byte
        send_byte(8'h77, 1'b0, 1'b0);
        check("pe_cnt1", bc_a, 1);
        send_byte(8'h88, 1'b1, 1'b0);
        check("pe_error", fe_a, 1);
        check("pe_data", fd_a, 16'hEEEE);
        check("pe_novalid", fv_a, 0);
        check("pe_cnt0", bc_a, 0);
        check("pe_state", st_a, 2);
        send_byte(8'h99, 1'b0, 1'b0);
        check("err_ignores_stb", bc_a, 0);
        check("err_data_kept", fd_a, 16'hEEEE);
        @(negedge clk);
        rx_perror = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        rx_perror = 1'b0;
        clr_err = 1'b0;
        check("clr_with_err", fe_a, 1);
        pulse_clr();
        check("clr_error", fe_a, 0);
        check("clr_data", fd_a, 16'hCCCC);
        check("clr_state", st_a, 0);

        // Framing error from IDLE
        @(negedge clk);
        rx_ferror = 1'b1;
        @(negedge clk);
        rx_ferror = 1'b0;
        check("fe_error", fe_a, 1);
        check("fe_data", fd_a, 16'hEEEE);
        pulse_clr();
        check("fe_clr", fe_a, 0);

        // Good frame after recovering from error
        exp_q.push_back(16'h5AA5);
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'hFF, 1'b0, 1'b0);
`endif
        check("post_err_frame", fd_a, 16'h5AA5);

`ifdef RX_FRAME_CHECKSUM_EN
        // Checksum good then bad
        exp_q.push_back(16'h1234);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        check("cs_cnt2", bc_a, 2);
        send_byte(8'h26, 1'b0, 1'b0);
        check("cs_good", fd_a, 16'h1234);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        check("cs_bad_err", fe_a, 1);
        check("cs_bad_data", fd_a, 16'hEEEE);
        check("cs_bad_novalid", fv_a, 0);
        pulse_clr();
`endif

        // Reset mid-frame drops the partial frame
        send_byte(8'h12, 1'b0, 1'b0);
        check("mid_cnt1", bc_a, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_cnt", bc_a, 0);
        check("mid_rst_data", fd_a, 16'hCCCC);
        exp_q.push_back(16'h0908);
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'h01, 1'b0, 1'b0);
`endif
        check("mid_rst_frame", fd_a, 16'h0908);

        repeat (2) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
